// File: rtl/dmem_pkg.sv
// Shared types, widths and the access-fault check for the data-memory responder.
package dmem_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  // off is the byte offset from the base address. be selects the bytes being
  // touched: a full-word access passes all ones, and an empty mask never faults
  // on alignment.
  function automatic logic dmem_fault(input logic [ADDR_W-1:0] off,
                                      input logic [BE_W-1:0]   be,
                                      input int unsigned       idx_w);
    logic [1:0] lo;
    lo = '0;
    for (int i = BE_W-1; i >= 0; i--)
      if (be[i]) lo = 2'(i);
    return ((off >> (idx_w + 2)) != '0) || ((be != '0) && (off[1:0] != lo));
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
  import dmem_pkg::*;
  logic              i_req;
  logic              i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic [BE_W-1:0]   i_be;
  logic              o_gnt;
  logic              o_rvalid;
  logic [DATA_W-1:0] o_rdata;
  logic              o_err;

  modport master (output i_req, i_we, i_addr, i_wdata, i_be,
                  input  o_gnt, o_rvalid, o_rdata, o_err);
  modport slave  (input  i_req, i_we, i_addr, i_wdata, i_be,
                  output o_gnt, o_rvalid, o_rdata, o_err);
endinterface

// File: rtl/dmem_array.sv
// Word-organised RAM: synchronous write with per-byte enables, synchronous read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i)
      for (int b = 0; b < BE_W; b++)
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one access at a time, WAIT_CYCLES wait states, fault on misaligned/out-of-range.
// Define DMEM_BYTE_STRB_EN to honour i_be on stores (byte-span alignment check).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  dmem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant, commit, live, fault;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr, off;
  logic [DATA_W-1:0] cur_wdata, ram_rdata;
  logic [BE_W-1:0]   cur_be;

  // With zero wait states the grant edge is also the commit edge, so the
  // access must be taken from the bus rather than from the latched copy.
  assign live      = (state_q == IDLE);
  assign cur_we    = live ? bus.i_we    : we_q;
  assign cur_addr  = live ? bus.i_addr  : addr_q;
  assign cur_wdata = live ? bus.i_wdata : wdata_q;

`ifdef DMEM_BYTE_STRB_EN
  logic [BE_W-1:0] be_q;
  assign cur_be = live ? bus.i_be : be_q;
  always_ff @(posedge i_clk) if (grant) be_q <= bus.i_be;
`else
  logic unused_be;
  assign unused_be = ^bus.i_be;
  assign cur_be    = '1;
`endif

  assign off   = cur_addr - BASE_ADDR;
  assign fault = dmem_fault(off, cur_be, IDX_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (bus.i_req) begin
        grant = 1'b1;
        if (WAIT_CYCLES == 0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = 4'(WAIT_CYCLES - 1);
        end
      end
      WAIT: if (cnt_q == '0) begin
        state_d = RESP;
        commit  = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) err_q <= fault;
    end
  end

  always_ff @(posedge i_clk) begin
    if (grant) begin
      we_q    <= bus.i_we;
      addr_q  <= bus.i_addr;
      wdata_q <= bus.i_wdata;
    end
  end

  // The RAM reads the current word every cycle; the read captured on the
  // commit edge is what RESP presents.
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk_i   (i_clk),
    .we_i    (commit & cur_we & ~fault & ~i_reset),
    .be_i    (cur_be),
    .addr_i  (off[IDX_W+1:2]),
    .wdata_i (cur_wdata),
    .rdata_o (ram_rdata)
  );

  assign bus.o_gnt    = grant & ~i_reset;
  assign bus.o_rvalid = (state_q == RESP);
  assign bus.o_err    = bus.o_rvalid & err_q;
  assign bus.o_rdata  = (bus.o_rvalid & ~we_q & ~err_q) ? ram_rdata : '0;
endmodule
